// File: rtl/sm_violation_pkg.sv
// Shared encodings for the SPM violation handler: FSM states and the
// access-kind codes recorded in the first-violation log.
package sm_violation_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [1:0] KIND_NONE  = 2'b00;
  localparam logic [1:0] KIND_EXEC  = 2'b01;
  localparam logic [1:0] KIND_READ  = 2'b10;
  localparam logic [1:0] KIND_WRITE = 2'b11;

  function automatic logic [1:0] decode_kind(input logic data_en, input logic data_wr);
    if (!data_en) return KIND_EXEC;
    return data_wr ? KIND_WRITE : KIND_READ;
  endfunction

endpackage

// File: rtl/sm_viol_timer.sv
// Loadable down-counter that times the reset pulse and the hold-off window.
// Load takes priority over decrement; the counter never goes below zero.
module sm_viol_timer #(
  parameter int W = 3
) (
  input  logic         mclk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sm_violation_handler.sv
// Turns a raw SPM violation into a fixed-length PUC pulse plus hold-off window,
// and keeps a sticky first-violation log and a saturating episode counter.
module sm_violation_handler
  import sm_violation_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int HOLD_OFF   = 2,
  parameter int CNT_W      = 8
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             violation,
  input  logic [15:0]      pc,
  input  logic [15:0]      data_addr,
  input  logic             data_en,
  input  logic             data_wr,
  input  logic             clear_log,
  output logic             reset,
  output logic             log_valid,
  output logic             log_overflow,
  output logic [15:0]      log_pc,
  output logic [15:0]      log_addr,
  output logic [1:0]       log_kind,
  output logic [CNT_W-1:0] viol_count,
  output logic             busy
);

  localparam int MAX_CYC = (RST_CYCLES > HOLD_OFF) ? RST_CYCLES : HOLD_OFF;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]    RST_LOAD  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0]    HOLD_LOAD = TW'((HOLD_OFF > 0) ? HOLD_OFF - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t        state;
  logic          accept;
  logic          t_load;
  logic          t_dec;
  logic          t_zero;
  logic [TW-1:0] t_val;

  // Violations are only accepted from IDLE; ASSERT and HOLD swallow them.
  assign accept = (state == IDLE) && violation;

  always_comb begin
    t_load = 1'b0;
    t_dec  = 1'b0;
    t_val  = RST_LOAD;
    case (state)
      IDLE: t_load = violation;
      ASSERT: begin
        if (t_zero) begin
          t_load = (HOLD_OFF > 0);
          t_val  = HOLD_LOAD;
        end else begin
          t_dec = 1'b1;
        end
      end
      HOLD:    t_dec = !t_zero;
      default: ;
    endcase
  end

  sm_viol_timer #(.W(TW)) u_timer (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .dec      (t_dec),
    .zero     (t_zero)
  );

  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      state <= IDLE;
      reset <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (violation) begin
            state <= ASSERT;
            reset <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ASSERT: begin
          if (t_zero) begin
            reset <= 1'b0;
            if (HOLD_OFF > 0) begin
              state <= HOLD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (t_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          reset <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // A fresh capture wins over a simultaneous clear_log.
  always_ff @(posedge mclk) begin
    if (!reset_n) begin
      log_valid    <= 1'b0;
      log_overflow <= 1'b0;
      log_pc       <= '0;
      log_addr     <= '0;
      log_kind     <= KIND_NONE;
      viol_count   <= '0;
    end else begin
      if (accept && (!log_valid || clear_log)) begin
        log_valid    <= 1'b1;
        log_overflow <= 1'b0;
        log_pc       <= pc;
        log_addr     <= data_en ? data_addr : 16'h0000;
        log_kind     <= decode_kind(data_en, data_wr);
      end else if (accept) begin
        log_overflow <= 1'b1;
      end else if (clear_log) begin
        log_valid    <= 1'b0;
        log_overflow <= 1'b0;
        log_pc       <= '0;
        log_addr     <= '0;
        log_kind     <= KIND_NONE;
      end
      if (accept && (viol_count != CNT_MAX)) begin
        viol_count <= viol_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sm_violation_handler.sv
// Directed bench for sm_violation_handler: a default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation check.
module tb_sm_violation_handler;

  logic        mclk;
  logic        reset_n;
  logic        violation;
  logic [15:0] pc;
  logic [15:0] data_addr;
  logic        data_en;
  logic        data_wr;
  logic        clear_log;

  logic        reset_a, log_valid_a, log_overflow_a, busy_a;
  logic [15:0] log_pc_a, log_addr_a;
  logic [1:0]  log_kind_a;
  logic [7:0]  viol_count_a;

  logic        reset_b, log_valid_b, log_overflow_b, busy_b;
  logic [15:0] log_pc_b, log_addr_b;
  logic [1:0]  log_kind_b;
  logic [1:0]  viol_count_b;

  int n_checks = 0;
  int n_fail   = 0;

  sm_violation_handler #(.RST_CYCLES(4), .HOLD_OFF(2), .CNT_W(8)) dut_a (
    .mclk (mclk), .reset_n (reset_n), .violation (violation), .pc (pc),
    .data_addr (data_addr), .data_en (data_en), .data_wr (data_wr),
    .clear_log (clear_log), .reset (reset_a), .log_valid (log_valid_a),
    .log_overflow (log_overflow_a), .log_pc (log_pc_a), .log_addr (log_addr_a),
    .log_kind (log_kind_a), .viol_count (viol_count_a), .busy (busy_a)
  );

  sm_violation_handler #(.RST_CYCLES(4), .HOLD_OFF(2), .CNT_W(2)) dut_b (
    .mclk (mclk), .reset_n (reset_n), .violation (violation), .pc (pc),
    .data_addr (data_addr), .data_en (data_en), .data_wr (data_wr),
    .clear_log (clear_log), .reset (reset_b), .log_valid (log_valid_b),
    .log_overflow (log_overflow_b), .log_pc (log_pc_b), .log_addr (log_addr_b),
    .log_kind (log_kind_b), .viol_count (viol_count_b), .busy (busy_b)
  );

  // clock / reset
  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Advance n rising edges; outputs are then read 1 time unit after the edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    violation = 1'b0;
    clear_log = 1'b0;
    data_en   = 1'b0;
    data_wr   = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    pc        = 16'h0000;
    data_addr = 16'h0000;
    drive_idle();
    tick(2);
    chk("rst_reset",    32'(reset_a),      0);
    chk("rst_busy",     32'(busy_a),       0);
    chk("rst_valid",    32'(log_valid_a),  0);
    chk("rst_kind",     32'(log_kind_a),   0);
    chk("rst_count",    32'(viol_count_a), 0);
    reset_n = 1'b1;
    tick(1);

    // 1: single data-write violation
    violation = 1'b1; pc = 16'hA010; data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0600;
    tick(1);
    drive_idle();
    chk("t1_reset_c1",  32'(reset_a),      1);
    chk("t1_busy_c1",   32'(busy_a),       1);
    chk("t1_valid",     32'(log_valid_a),  1);
    chk("t1_kind",      32'(log_kind_a),   3);
    chk("t1_pc",        32'(log_pc_a),     32'hA010);
    chk("t1_addr",      32'(log_addr_a),   32'h0600);
    chk("t1_count",     32'(viol_count_a), 1);
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      chk($sformatf("t1_reset_e%0d", i), 32'(reset_a), (i <= 3) ? 1 : 0);
      chk($sformatf("t1_busy_e%0d", i),  32'(busy_a),  (i <= 5) ? 1 : 0);
    end

    // 2: clear the log, then an execute violation
    clear_log = 1'b1;
    tick(1);
    clear_log = 1'b0;
    chk("t2_clr_valid", 32'(log_valid_a),  0);
    chk("t2_clr_pc",    32'(log_pc_a),     0);
    chk("t2_clr_kind",  32'(log_kind_a),   0);
    violation = 1'b1; pc = 16'hB000; data_en = 1'b0; data_addr = 16'h1234;
    tick(1);
    drive_idle();
    chk("t2_kind",      32'(log_kind_a),   1);
    chk("t2_addr",      32'(log_addr_a),   0);
    chk("t2_pc",        32'(log_pc_a),     32'hB000);
    chk("t2_count",     32'(viol_count_a), 2);
    tick(7);
    chk("t2_idle",      32'(busy_a),       0);

    // 3: violation held for 20 edges -> episodes at edges 0, 7, 14
    violation = 1'b1; pc = 16'hC000; data_en = 1'b1; data_wr = 1'b0; data_addr = 16'h0700;
    tick(20);
    chk("t3_count",     32'(viol_count_a),   5);
    chk("t3_pc",        32'(log_pc_a),       32'hB000);
    chk("t3_kind",      32'(log_kind_a),     1);
    chk("t3_overflow",  32'(log_overflow_a), 1);
    chk("t3_hold_rst",  32'(reset_a),        0);
    chk("t3_hold_busy", 32'(busy_a),         1);
    drive_idle();
    tick(2);
    chk("t3_idle",      32'(busy_a),         0);

    // 4: clear_log together with an accepted violation
    clear_log = 1'b1; violation = 1'b1; pc = 16'hD00D;
    data_en = 1'b1; data_wr = 1'b1; data_addr = 16'h0ABC;
    tick(1);
    drive_idle();
    chk("t4_valid",     32'(log_valid_a),    1);
    chk("t4_pc",        32'(log_pc_a),       32'hD00D);
    chk("t4_addr",      32'(log_addr_a),     32'h0ABC);
    chk("t4_kind",      32'(log_kind_a),     3);
    chk("t4_overflow",  32'(log_overflow_a), 0);
    chk("t4_count",     32'(viol_count_a),   6);

    // 5: reset_n mid-ASSERT
    tick(1);
    chk("t5_in_assert", 32'(reset_a),        1);
    reset_n = 1'b0;
    tick(1);
    chk("t5_reset",     32'(reset_a),        0);
    chk("t5_busy",      32'(busy_a),         0);
    chk("t5_valid",     32'(log_valid_a),    0);
    chk("t5_pc",        32'(log_pc_a),       0);
    chk("t5_count_a",   32'(viol_count_a),   0);
    chk("t5_count_b",   32'(viol_count_b),   0);
    reset_n = 1'b1;
    tick(1);

    // 6: five separated violations; 2-bit counter saturates at 3
    for (int k = 0; k < 5; k++) begin
      violation = 1'b1; pc = 16'(16'h0100 + k);
      tick(1);
      drive_idle();
      tick(8);
    end
    chk("t6_count_b",   32'(viol_count_b),   3);
    chk("t6_count_a",   32'(viol_count_a),   5);
    chk("t6_pc_b",      32'(log_pc_b),       32'h0100);
    chk("t6_kind_b",    32'(log_kind_b),     1);
    chk("t6_ovf_b",     32'(log_overflow_b), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sm_violation_handler.md
Name: sm_violation_handler

Overview:
- Downstream consumer of the Sancus SPM violation flag. Sits between the spm_control violation output and the core PUC request.
- Turns the single-cycle raw violation into a fixed-length reset pulse, followed by a hold-off window.
- Keeps a sticky first-violation log (pc, address, access kind) and a saturating violation counter, readable by debug logic.
- The log survives the PUC it generates; only reset_n clears it.

Parameters:
- RST_CYCLES, 4: cycles the reset output stays high per violation episode (>=1).
- HOLD_OFF, 2: cycles after reset deassertion during which violations are ignored (>=0).
- CNT_W, 8: width of the violation counter.

Ports:
- mclk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low block reset.
- violation  in  1  raw SPM violation, combinational from spm_control, sampled each edge.
- pc  in  16  current instruction PC.
- data_addr  in  16  data memory address bus.
- data_en  in  1  data access enable.
- data_wr  in  1  data write strobe.
- clear_log  in  1  one-cycle pulse; clears log_valid and log_overflow.
- reset  out  1  PUC request to the core.
- log_valid  out  1  log holds a captured violation.
- log_overflow  out  1  further violation(s) occurred while log_valid=1.
- log_pc  out  16  PC at the captured violation.
- log_addr  out  16  data_addr at capture; 0 for execute-kind violations.
- log_kind  out  2  00 none, 01 exec, 10 data read, 11 data write.
- viol_count  out  CNT_W  number of accepted violation episodes, saturating.
- busy  out  1  1 when state != IDLE.

Behaviour:
- Synchronous reset (reset_n=0 at an edge):
  - state <= IDLE; all outputs 0.
  - Timer cleared.
  - Dominates every other input, including mid-episode.
- FSM states: IDLE, ASSERT, HOLD.
  - IDLE:
    - violation=1 at an edge: accept the episode, go to ASSERT, timer <= RST_CYCLES-1.
    - reset reads 1 in the cycle after the sampling edge (latency 1).
  - ASSERT:
    - reset=1.
    - Timer decrements each edge.
    - At timer=0: if HOLD_OFF>0, go to HOLD with timer <= HOLD_OFF-1; else go to IDLE.
    - reset is high for exactly RST_CYCLES cycles.
  - HOLD:
    - reset=0.
    - Timer decrements each edge.
    - At timer=0: go to IDLE.
    - A violation on the same edge that returns to IDLE is not accepted; it must persist to the next edge.
  - violation while in ASSERT or HOLD: ignored (no count, no log change, no overflow).
- Kind decode at acceptance:
  - data_en=0 -> 01, log_addr <= 0.
  - data_en=1, data_wr=0 -> 10.
  - data_en=1, data_wr=1 -> 11.
- Log update on an accepted violation:
  - log_valid=0: capture pc, addr, kind; log_valid <= 1.
  - log_valid=1: log fields unchanged; log_overflow <= 1.
- clear_log (only when no violation is accepted on the same edge): log_valid <= 0, log_overflow <= 0; log_pc, log_addr, log_kind <= 0.
- clear_log on the same edge as an accepted violation: the new capture wins (log_valid=1 with new fields, log_overflow=0).
- viol_count: +1 per accepted episode; holds at 2^CNT_W-1, no wrap.
- The reset output never resets this block.

Decomposition:
- Shared package (sm_violation_pkg):
  - state encoding constants IDLE/ASSERT/HOLD;
  - KIND_NONE/EXEC/READ/WRITE codes.
- One natural sub-module: sm_viol_timer.
  - Loadable down-counter with load value, load enable, decrement enable, and a zero flag.
  - Width is $clog2 of max(RST_CYCLES, HOLD_OFF)+1.
- FSM, log and counter live in the top module.

Test Plan:
1. Single violation: reset_n released; violation=1 for one cycle with pc=A010, data_en=1, data_wr=1, data_addr=0600.
   - reset high cycles 1–4 after the edge; busy high for 6 cycles.
   - log_valid=1, log_kind=11, log_pc=A010, log_addr=0600, viol_count=1.
2. Execute violation with data_en=0, pc=B000: log_kind=01, log_addr=0000.
3. Violation held high continuously for 20 cycles (RST_CYCLES=4, HOLD_OFF=2): one episode every 7 cycles.
   - viol_count=3 after 20 cycles.
   - log keeps the first capture; log_overflow=1.
4. clear_log and an accepted violation on the same edge: log_valid=1 with the new pc, log_overflow=0.
5. reset_n=0 asserted during ASSERT: next cycle reset=0, busy=0, log cleared, viol_count=0.
6. CNT_W=2, five separated violations: viol_count saturates at 3.
